// File: rtl/tdm_demux.sv
// tdm_demux: steers a shared valid/ready stream into two registered output
// channels. The AND channel is selected by 1 and the OR channel by 0. The
// destination comes from in_sel, or from an internal alternating sequencer
// when auto_mode=1.
// Optional feature macro: TDM_DEMUX_COUNT_EN adds 8-bit saturating delivery
// counters. Without the macro, and_cnt/or_cnt read 0 and cnt_clr is ignored.
//
// Handshake semantics, identical on every port pair:
//   A transfer happens on a rising edge where valid && ready are both high.
//   A producer holds its data and valid stable until that transfer happens.
//   in_ready never depends on in_valid. and_valid and or_valid never depend
//   on and_ready or or_ready in the same cycle.
module tdm_demux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sel,
  output logic             in_ready,
  input  logic             auto_mode,
  output logic             slot_sel,
  output logic [WIDTH-1:0] and_data,
  output logic             and_valid,
  input  logic             and_ready,
  output logic [WIDTH-1:0] or_data,
  output logic             or_valid,
  input  logic             or_ready,
  input  logic             cnt_clr,
  output logic [7:0]       and_cnt,
  output logic [7:0]       or_cnt
);

  // The sequencer state is visible on slot_sel whenever auto_mode=1.
  typedef enum logic {
    SLOT_OR  = 1'b0,
    SLOT_AND = 1'b1
  } slot_t;

  slot_t state;
  slot_t state_next;
  logic  accept;
  logic  and_load;
  logic  or_load;
  logic  and_take;
  logic  or_take;

  assign slot_sel = auto_mode ? (state == SLOT_AND) : in_sel;

  // A destination can accept when its slot is empty, or when it drains on
  // the same edge (pass-through refill).
  assign in_ready = slot_sel ? (!and_valid || and_ready)
                             : (!or_valid  || or_ready);

  assign accept   = in_valid && in_ready;
  assign and_load = accept && slot_sel;
  assign or_load  = accept && !slot_sel;
  assign and_take = and_valid && and_ready;
  assign or_take  = or_valid && or_ready;

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SLOT_OR;
    else        state <= state_next;
  end

  // Sequencer next state: alternate on each accept. Outside auto mode the
  // state is pinned to SLOT_OR, so every auto burst starts with the OR slot.
  always_comb begin
    state_next = state;
    if (!auto_mode) begin
      state_next = SLOT_OR;
    end else if (accept) begin
      state_next = (state == SLOT_OR) ? SLOT_AND : SLOT_OR;
    end
  end

  // AND channel slot: data changes only on load; valid clears on drain
  // unless the slot is refilled on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      and_data  <= '0;
      and_valid <= 1'b0;
    end else if (and_load) begin
      and_data  <= in_data;
      and_valid <= 1'b1;
    end else if (and_take) begin
      and_valid <= 1'b0;
    end
  end

  // OR channel slot: same behaviour as the AND slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_data  <= '0;
      or_valid <= 1'b0;
    end else if (or_load) begin
      or_data  <= in_data;
      or_valid <= 1'b1;
    end else if (or_take) begin
      or_valid <= 1'b0;
    end
  end

`ifdef TDM_DEMUX_COUNT_EN
  // Delivery counters: count channel handshakes and saturate at 255.
  // A clear takes priority over an increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      and_cnt <= 8'd0;
      or_cnt  <= 8'd0;
    end else if (cnt_clr) begin
      and_cnt <= 8'd0;
      or_cnt  <= 8'd0;
    end else begin
      if (and_take && (and_cnt != 8'hFF)) and_cnt <= and_cnt + 8'd1;
      if (or_take && (or_cnt != 8'hFF))   or_cnt  <= or_cnt + 8'd1;
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign and_cnt = 8'd0;
  assign or_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed bench for tdm_demux. It covers select routing,
// backpressure, channel independence, the auto-alternate sequencer, reset
// in the middle of a stream, and the delivery counters when they are
// compiled in (TDM_DEMUX_COUNT_EN).
module tb_tdm_demux;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_sel;
  logic             in_ready;
  logic             auto_mode;
  logic             slot_sel;
  logic [WIDTH-1:0] and_data;
  logic             and_valid;
  logic             and_ready;
  logic [WIDTH-1:0] or_data;
  logic             or_valid;
  logic             or_ready;
  logic             cnt_clr;
  logic [7:0]       and_cnt;
  logic [7:0]       or_cnt;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_and_q[$];
  logic [WIDTH-1:0] exp_or_q[$];

  tdm_demux #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_ready  (in_ready),
    .auto_mode (auto_mode),
    .slot_sel  (slot_sel),
    .and_data  (and_data),
    .and_valid (and_valid),
    .and_ready (and_ready),
    .or_data   (or_data),
    .or_valid  (or_valid),
    .or_ready  (or_ready),
    .cnt_clr   (cnt_clr),
    .and_cnt   (and_cnt),
    .or_cnt    (or_cnt)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Driver: offer one word and hold it until accepted (bounded wait).
  task automatic send(input logic [WIDTH-1:0] d, input logic s);
    bit ok;
    ok       = 1'b0;
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      chk("send_timeout", 32'(0), 32'(1));
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: at the negedge, a visible handshake completes on the next
  // edge. Compare the word against the expected order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (and_valid && and_ready) begin
        if (exp_and_q.size() == 0) chk("and_unexpected", 32'(and_data), 32'hFFFF_FFFF);
        else chk("and_deliver", 32'(and_data), 32'(exp_and_q.pop_front()));
      end
      if (or_valid && or_ready) begin
        if (exp_or_q.size() == 0) chk("or_unexpected", 32'(or_data), 32'hFFFF_FFFF);
        else chk("or_deliver", 32'(or_data), 32'(exp_or_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_sel    = 1'b0;
    auto_mode = 1'b0;
    and_ready = 1'b1;
    or_ready  = 1'b1;
    cnt_clr   = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_and_valid", 32'(and_valid), 32'(0));
    chk("rst_or_valid", 32'(or_valid), 32'(0));
    chk("rst_and_data", 32'(and_data), 32'(0));
    chk("rst_or_data", 32'(or_data), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_slot_sel", 32'(slot_sel), 32'(0));
    chk("rst_and_cnt", 32'(and_cnt), 32'(0));
    in_sel = 1'b1;
    #1;
    chk("rst_slot_sel_follows_sel", 32'(slot_sel), 32'(1));
    rst_n = 1'b1;
    idle(1);

    // Select routing with one-cycle latency.
    exp_and_q.push_back(8'h11);
    send(8'h11, 1'b1);
    chk("route_and_valid", 32'(and_valid), 32'(1));
    chk("route_and_data", 32'(and_data), 32'h11);
    exp_or_q.push_back(8'h22);
    send(8'h22, 1'b0);
    chk("route_or_valid", 32'(or_valid), 32'(1));
    chk("route_or_data", 32'(or_data), 32'h22);
    idle(2);
    chk("route_drained_and", 32'(and_valid), 32'(0));
    chk("route_drained_or", 32'(or_valid), 32'(0));
    chk("route_and_data_held", 32'(and_data), 32'h11);

    // Backpressure: A2 waits while A1 is stalled, then refills on drain.
    and_ready = 1'b0;
    exp_and_q.push_back(8'hA1);
    exp_and_q.push_back(8'hA2);
    send(8'hA1, 1'b1);
    fork
      send(8'hA2, 1'b1);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready_low", 32'(in_ready), 32'(0));
          chk("bp_and_data_held", 32'(and_data), 32'hA1);
        end
        @(posedge clk);
        #1;
        and_ready = 1'b1;
      end
    join
    chk("bp_refill_data", 32'(and_data), 32'hA2);
    chk("bp_refill_valid", 32'(and_valid), 32'(1));
    idle(1);
    chk("bp_drained", 32'(and_valid), 32'(0));

    // Independence: a stalled AND slot does not block OR traffic.
    and_ready = 1'b0;
    exp_and_q.push_back(8'hB1);
    send(8'hB1, 1'b1);
    in_sel = 1'b1;
    #1;
    chk("ind_and_blocked", 32'(in_ready), 32'(0));
    in_sel = 1'b0;
    #1;
    chk("ind_or_open", 32'(in_ready), 32'(1));
    exp_or_q.push_back(8'h5C);
    send(8'h5C, 1'b0);
    chk("ind_or_data", 32'(or_data), 32'h5C);
    chk("ind_and_still_full", 32'(and_valid), 32'(1));
    and_ready = 1'b1;
    idle(2);

    // Auto mode: OR, AND, OR, AND regardless of in_sel.
    auto_mode = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      logic [WIDTH-1:0] w;
      w = 8'(i + 1);
      chk("auto_slot_sel", 32'(slot_sel), 32'(i % 2));
      if (i % 2 == 0) exp_or_q.push_back(w);
      else exp_and_q.push_back(w);
      send(w, 1'($urandom_range(0, 1)));
    end
    chk("auto_last_and", 32'(and_data), 32'h04);
    chk("auto_last_or", 32'(or_data), 32'h03);
    auto_mode = 1'b0;
    idle(2);

    // Reset mid-stream with both slots full and the sequencer at SLOT_AND.
    and_ready = 1'b0;
    or_ready  = 1'b0;
    exp_and_q.push_back(8'h70);
    send(8'h70, 1'b1);
    auto_mode = 1'b1;
    exp_or_q.push_back(8'h71);
    send(8'h71, 1'b1);
    chk("mid_slot_sel_and", 32'(slot_sel), 32'(1));
    chk("mid_both_full", 32'({and_valid, or_valid}), 32'(3));
    #2;
    rst_n = 1'b0;
    exp_and_q.delete();
    exp_or_q.delete();
    #1;
    chk("mid_rst_and_valid", 32'(and_valid), 32'(0));
    chk("mid_rst_or_valid", 32'(or_valid), 32'(0));
    chk("mid_rst_slot_sel", 32'(slot_sel), 32'(0));
    chk("mid_rst_and_data", 32'(and_data), 32'(0));
    idle(1);
    rst_n     = 1'b1;
    auto_mode = 1'b0;
    and_ready = 1'b1;
    or_ready  = 1'b1;
    idle(1);

`ifdef TDM_DEMUX_COUNT_EN
    // Counters: saturate after 300 AND deliveries, then clear beats increment.
    for (int i = 0; i < 300; i++) begin
      exp_and_q.push_back(8'(i));
      send(8'(i), 1'b1);
    end
    idle(2);
    chk("cnt_and_sat", 32'(and_cnt), 32'd255);
    chk("cnt_or_zero", 32'(or_cnt), 32'd0);
    and_ready = 1'b0;
    exp_and_q.push_back(8'h99);
    send(8'h99, 1'b1);
    and_ready = 1'b1;
    cnt_clr   = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    chk("cnt_clr_wins", 32'(and_cnt), 32'd0);
    exp_or_q.push_back(8'h42);
    send(8'h42, 1'b0);
    idle(2);
    chk("cnt_or_one", 32'(or_cnt), 32'd1);
`else
    exp_or_q.push_back(8'h42);
    send(8'h42, 1'b0);
    idle(2);
    chk("cnt_absent_and", 32'(and_cnt), 32'd0);
    chk("cnt_absent_or", 32'(or_cnt), 32'd0);
`endif

    // Final report.
    idle(2);
    chk("and_q_empty", 32'(exp_and_q.size()), 32'(0));
    chk("or_q_empty", 32'(exp_or_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Receiving end of the select-driven AND/OR channel mux. It takes one shared data stream plus a select line and steers each accepted word to one of two registered output channels, the AND channel or the OR channel. Each channel has its own valid/ready handshake. An optional auto-alternate sequencer reconstructs a strict time-division stream without a select wire. It sits between the mux/link logic and the per-channel consumers.

## Interface
- `WIDTH`, default 8: data width of the shared stream and of both channels.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_data`  input  WIDTH  shared stream data.
- `in_valid`  input  1  `in_data` is valid this cycle.
- `in_sel`  input  1  destination select: 1 = AND channel, 0 = OR channel. Ignored while `auto_mode`=1.
- `in_ready`  output  1  the block accepts `in_data` this cycle.
- `auto_mode`  input  1  1 = internal alternating sequencer chooses the destination.
- `slot_sel`  output  1  destination of the next accepted word (1 = AND, 0 = OR).
- `and_data`  output  WIDTH  AND channel data.
- `and_valid`  output  1  AND channel holds a word.
- `and_ready`  input  1  AND consumer takes the word.
- `or_data`  output  WIDTH  OR channel data.
- `or_valid`  output  1  OR channel holds a word.
- `or_ready`  input  1  OR consumer takes the word.
- `cnt_clr`  input  1  synchronous clear of the delivery counters (only with `TDM_DEMUX_COUNT_EN`).
- `and_cnt`  output  8  AND words delivered (only with `TDM_DEMUX_COUNT_EN`).
- `or_cnt`  output  8  OR words delivered (only with `TDM_DEMUX_COUNT_EN`).

## Operation
- Destination:
  - `auto_mode`=0: `slot_sel` = `in_sel`.
  - `auto_mode`=1: `slot_sel` = sequencer state.
- Each channel has one output register: a data word plus a valid flag.
- Accept: `in_valid && in_ready`.
- `in_ready` = destination slot empty OR destination channel's ready high this cycle (drain-and-refill pass-through). Combinational from `auto_mode`, `in_sel`, state, valid flags and both ready inputs. It does not depend on `in_valid`.
- On accept: destination register loads `in_data` and its valid flag sets. The other channel is untouched.
- On channel handshake (valid && ready) without a same-cycle refill: the valid flag clears and the data register holds its last value.
- Data registers change only on load. They are never cleared except by reset.
- Sequencer states SLOT_OR (`slot_sel`=0) and SLOT_AND (`slot_sel`=1):
  - SLOT_OR → SLOT_AND on accept.
  - SLOT_AND → SLOT_OR on accept.
  - No accept: state holds.
  - While `auto_mode`=0 the state is forced to SLOT_OR each cycle, so every auto burst starts with the OR slot.
- Both channels drain independently. A stalled AND consumer never blocks OR traffic in select mode. In auto mode it blocks only when the sequencer points at AND.

## Timing
- Reset values: `and_valid`=`or_valid`=0; `and_data`=`or_data`=0; sequencer SLOT_OR; counters 0.
- `in_ready` with both slots empty after reset is 1. `slot_sel` after reset is 0, or `in_sel` when `auto_mode`=0.
- Latency: a word accepted on edge N is visible on its channel with valid=1 after edge N, i.e. one cycle.
- Full slot with ready=0: `in_ready`=0 for that destination. The word stays on the input, no loss and no duplicate.
- Full slot with ready=1 and a new accept in the same cycle: old word delivered and new word loaded on the same edge; valid stays 1. Throughput is one word per cycle per channel.
- `auto_mode` toggling mid-stream: takes effect at the next edge. A word offered in the toggle cycle uses the destination computed from the current `auto_mode` value.
- Reset asserted mid-operation: all valid flags drop immediately (asynchronous). Words held in the slots are discarded.

## Configuration
- `TDM_DEMUX_COUNT_EN` defined: two 8-bit delivery counters are compiled in.
  - `and_cnt`/`or_cnt` increment on the respective channel handshake and saturate at 255.
  - `cnt_clr`=1 zeroes both counters on the next edge; clear wins over a same-cycle increment.
- Macro undefined: counters are absent, `and_cnt`/`or_cnt` are tied to 0 and `cnt_clr` is ignored.

## Test plan
- Reset then select routing: send 0x11 with `in_sel`=1 and 0x22 with `in_sel`=0, both readies=1 → `and_data`=0x11 valid one cycle after accept; `or_data`=0x22 valid one cycle later.
- Backpressure: `and_ready`=0, send 0xA1 then 0xA2 to AND → 0xA2 held with `in_ready`=0 until `and_ready`=1; delivered in order 0xA1, 0xA2, no drops.
- Independence: AND slot full and stalled, send 0x5C with `in_sel`=0 → `in_ready`=1 and `or_data`=0x5C delivered.
- Auto mode: `auto_mode`=1, stream 0x01,0x02,0x03,0x04, `in_sel` toggling randomly → OR gets 0x01,0x03; AND gets 0x02,0x04; `slot_sel` alternates 0,1,0,1.
- Reset mid-stream: both slots full, pulse `rst_n`=0 → both valids drop immediately; sequencer back to SLOT_OR.
- With `TDM_DEMUX_COUNT_EN`: 300 AND deliveries → `and_cnt`=255; `cnt_clr` on the same cycle as a delivery → counter 0.
